// File: rtl/jtvigil_pkg.sv
// Shared constants for the jtvigil graphics ROM arbiter.
// Requester indices, FSM states and round-robin helper.
package jtvigil_pkg;

  localparam logic [1:0] OBJ  = 2'd0;
  localparam logic [1:0] SCR  = 2'd1;
  localparam logic [1:0] CHR  = 2'd2;
  localparam logic [1:0] NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } gfx_state_t;

  // Requester visited at step i of a search that starts after p.
  function automatic logic [1:0] rr_idx(
    input logic [1:0] p,
    input int         i
  );
    int s;
    s = (int'(p) + i) % 3;
    return 2'(s);
  endfunction

endpackage

// File: rtl/jtvigil_gfx_pick.sv
// Winner select for the graphics ROM arbiter.
// Searches req bits starting after ptr; ptr=2 gives 0>1>2.
module jtvigil_gfx_pick
  import jtvigil_pkg::*;
(
  input  logic [2:0] cs,
  input  logic [1:0] ptr,
  output logic [1:0] win
);

  // First requesting unit in search order wins; NONE if idle.
  always_comb begin
    win = NONE;
    for (int i = 3; i >= 1; i--) begin
      if (cs[rr_idx(ptr, i)]) win = rr_idx(ptr, i);
    end
  end

endmodule

// File: rtl/jtvigil_gfx_arb.sv
// Graphics ROM arbiter: obj/scroll/char share one ROM port.
// JTVIGIL_GFX_RR_EN selects round-robin instead of fixed priority.
module jtvigil_gfx_arb
  import jtvigil_pkg::*;
#(
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int SETTLE = 2
) (
  input  logic            rst,
  input  logic            clk,
  input  logic [2:0]      req_cs,
  input  logic [3*AW-1:0] req_addr,
  output logic [2:0]      req_ok,
  output logic [DW-1:0]   req_data,
  output logic [1:0]      req_gnt,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic [DW-1:0]   rom_data,
  input  logic            rom_ok
);

  gfx_state_t    st;
  logic [1:0]    cnt;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [AW-1:0] win_addr;
  logic [AW-1:0] gnt_addr;
  logic          gnt_cs;
  logic          abort;
  logic          last;

  jtvigil_gfx_pick u_pick (
    .cs  (req_cs),
    .ptr (ptr),
    .win (win)
  );

  // Address of the arbitration winner.
  always_comb begin
    case (win)
      SCR:     win_addr = req_addr[AW +: AW];
      CHR:     win_addr = req_addr[2*AW +: AW];
      default: win_addr = req_addr[0 +: AW];
    endcase
  end

  // Request level and address of the unit being served.
  always_comb begin
    case (req_gnt)
      SCR: begin
        gnt_addr = req_addr[AW +: AW];
        gnt_cs   = req_cs[1];
      end
      CHR: begin
        gnt_addr = req_addr[2*AW +: AW];
        gnt_cs   = req_cs[2];
      end
      default: begin
        gnt_addr = req_addr[0 +: AW];
        gnt_cs   = req_cs[0];
      end
    endcase
  end

  // Abort on dropped request or moved address; last = final ok.
  always_comb begin
    abort = !gnt_cs || (gnt_addr != rom_addr);
    last  = rom_ok && (int'(cnt) + 1 >= SETTLE);
  end

  // Fetch sequencer: grant, qualify rom_ok, capture, gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      req_ok   <= '0;
      req_data <= '0;
      req_gnt  <= NONE;
    end else begin
      req_ok <= '0;
      case (st)
        IDLE: begin
          cnt <= '0;
          if (win != NONE) begin
            rom_addr <= win_addr;
            rom_cs   <= 1'b1;
            req_gnt  <= win;
            st       <= FETCH;
          end else begin
            rom_cs  <= 1'b0;
            req_gnt <= NONE;
          end
        end
        FETCH: begin
          if (abort) begin
            rom_cs  <= 1'b0;
            req_gnt <= NONE;
            cnt     <= '0;
            st      <= IDLE;
          end else if (!rom_ok) begin
            cnt <= '0;
          end else if (last) begin
            req_data <= rom_data;
            req_ok   <= 3'b001 << req_gnt;
            rom_cs   <= 1'b0;
            req_gnt  <= NONE;
            cnt      <= '0;
            st       <= DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          st <= IDLE;
        end
        default: begin
          st      <= IDLE;
          rom_cs  <= 1'b0;
          req_gnt <= NONE;
        end
      endcase
    end
  end

`ifdef JTVIGIL_GFX_RR_EN
  // Remember the last unit that completed; aborts leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CHR;
    end else if (st == FETCH && !abort && last) begin
      ptr <= req_gnt;
    end
  end
`else
  assign ptr = CHR;
`endif

endmodule

// File: tb/tb_jtvigil_gfx_arb.sv
// Randomized + directed bench for jtvigil_gfx_arb.
// Cycle-level reference model written from the fetch rules.
module tb_jtvigil_gfx_arb;

  localparam int AW     = 18;
  localparam int DW     = 32;
  localparam int SETTLE = 2;

  logic            rst;
  logic            clk;
  logic [2:0]      req_cs;
  logic [3*AW-1:0] req_addr;
  logic [2:0]      req_ok;
  logic [DW-1:0]   req_data;
  logic [1:0]      req_gnt;
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic [DW-1:0]   rom_data;
  logic            rom_ok;

  int checks = 0;
  int errors = 0;

  jtvigil_gfx_arb #(.AW(AW), .DW(DW), .SETTLE(SETTLE)) dut (
    .rst      (rst),
    .clk      (clk),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_ok   (req_ok),
    .req_data (req_data),
    .req_gnt  (req_gnt),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int            m_owner;
  int            m_run;
  bit            m_gap;
  int            m_last;
  logic          m_cs;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_gnt;
  logic [2:0]    m_ok;
  logic [DW-1:0] m_data;

  function automatic logic [AW-1:0] addr_of(input int n);
    return req_addr[n*AW +: AW];
  endfunction

  // Model: advances one clock edge from the documented rules.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_run = 0; m_gap = 0; m_last = 2;
        m_cs = 0; m_addr = '0; m_gnt = 3; m_ok = 0; m_data = '0;
      end else begin
        m_ok = 0;
        if (m_gap) begin
          m_gap = 0;
        end else if (m_owner < 0) begin
          int w;
          w = -1;
          for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (w < 0 && req_cs[c]) w = c;
          end
          if (w >= 0) begin
            m_owner = w; m_run = 0;
            m_addr = addr_of(w); m_cs = 1; m_gnt = 2'(w);
          end else begin
            m_cs = 0; m_gnt = 3;
          end
        end else if (!req_cs[m_owner] || addr_of(m_owner) != m_addr) begin
          m_owner = -1; m_run = 0; m_cs = 0; m_gnt = 3;
        end else if (rom_ok) begin
          m_run++;
          if (m_run >= SETTLE) begin
            m_data = rom_data;
            m_ok = 3'(1 << m_owner);
`ifdef JTVIGIL_GFX_RR_EN
            m_last = m_owner;
`endif
            m_owner = -1; m_run = 0; m_gap = 1;
            m_cs = 0; m_gnt = 3;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  // Compare process: all outputs against the model every cycle.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rom_cs", 64'(rom_cs), 64'(m_cs));
      check("m_rom_addr", 64'(rom_addr), 64'(m_addr));
      check("m_req_gnt", 64'(req_gnt), 64'(m_gnt));
      check("m_req_ok", 64'(req_ok), 64'(m_ok));
      check("m_req_data", 64'(req_data), 64'(m_data));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int n, input logic [AW-1:0] a);
    req_addr[n*AW +: AW] = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    req_cs = 0; rom_ok = 0;
    cyc(1);
  endtask

  logic [1:0] grants [$];
  logic [1:0] prev_gnt;
  logic [1:0] exp_g [4];

  initial begin
    rst = 1'b1;
    req_cs = 0; req_addr = '0; rom_data = '0; rom_ok = 0;
    #23;
    check("reset_rom_cs", 64'(rom_cs), 0);
    check("reset_rom_addr", 64'(rom_addr), 0);
    check("reset_req_ok", 64'(req_ok), 0);
    check("reset_req_data", 64'(req_data), 0);
    check("reset_req_gnt", 64'(req_gnt), 3);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;

    // Single request, rom_ok arrives late
    cyc(1);
    req_cs = 3'b001; set_addr(0, 18'h1234);
    cyc(1);
    check("single_cs", 64'(rom_cs), 1);
    check("single_addr", 64'(rom_addr), 64'h1234);
    check("single_gnt", 64'(req_gnt), 0);
    cyc(4);
    rom_ok = 1; rom_data = 32'hAAAA_0001;
    cyc(1);
    check("single_early", 64'(req_ok), 0);
    rom_data = 32'hCAFE_F00D;
    cyc(1);
    check("single_ok", 64'(req_ok), 64'b001);
    check("single_data", 64'(req_data), 64'hCAFE_F00D);
    check("single_drop_cs", 64'(rom_cs), 0);
    req_cs = 0; rom_ok = 0;
    cyc(1);
    check("single_done_gnt", 64'(req_gnt), 3);
    check("single_hold_data", 64'(req_data), 64'hCAFE_F00D);

    // Simultaneous requests held with rom_ok high
    do_reset();
    set_addr(0, 18'h10); set_addr(1, 18'h20); set_addr(2, 18'h30);
    req_cs = 3'b111; rom_ok = 1; rom_data = 32'h5;
    prev_gnt = 3;
    for (int i = 0; i < 18; i++) begin
      cyc(1);
      if (req_gnt != 3 && prev_gnt == 3) grants.push_back(req_gnt);
      prev_gnt = req_gnt;
    end
`ifdef JTVIGIL_GFX_RR_EN
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    check("sim_count", 64'(grants.size()), 5);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check("sim_order", 64'(grants[i]), 64'(exp_g[i]));
      else check("sim_order_missing", 64'(3), 64'(exp_g[i]));
    end
    req_cs = 0; rom_ok = 0;
    cyc(3);

    // rom_ok glitch 1,0,1,1
    do_reset();
    req_cs = 3'b010; set_addr(1, 18'h3_0000);
    cyc(1);
    check("glitch_gnt", 64'(req_gnt), 1);
    rom_ok = 1; rom_data = 32'h1; cyc(1);
    check("glitch_a", 64'(req_ok), 0);
    rom_ok = 0; cyc(1);
    check("glitch_b", 64'(req_ok), 0);
    rom_ok = 1; rom_data = 32'h2; cyc(1);
    check("glitch_c", 64'(req_ok), 0);
    rom_data = 32'h3; cyc(1);
    check("glitch_ok", 64'(req_ok), 64'b010);
    check("glitch_data", 64'(req_data), 3);
    req_cs = 0; rom_ok = 0;
    cyc(2);

    // Abort by dropping req_cs[1], requester 2 pending
    do_reset();
    set_addr(1, 18'h111); set_addr(2, 18'h222);
    req_cs = 3'b110;
    cyc(1);
    check("abort_gnt1", 64'(req_gnt), 1);
    cyc(1);
    req_cs = 3'b100;
    cyc(1);
    check("abort_cs", 64'(rom_cs), 0);
    check("abort_gnt", 64'(req_gnt), 3);
    check("abort_ok", 64'(req_ok), 0);
    cyc(1);
    check("abort_next_gnt", 64'(req_gnt), 2);
    check("abort_next_addr", 64'(rom_addr), 64'h222);
    rom_ok = 1; cyc(2);
    check("abort_next_ok", 64'(req_ok), 64'b100);
    req_cs = 0; rom_ok = 0;
    cyc(2);

    // Address change during fetch
    do_reset();
    req_cs = 3'b001; set_addr(0, 18'h100);
    cyc(1);
    check("achg_addr0", 64'(rom_addr), 64'h100);
    set_addr(0, 18'h102);
    cyc(1);
    check("achg_abort", 64'(rom_cs), 0);
    cyc(1);
    check("achg_cs", 64'(rom_cs), 1);
    check("achg_addr1", 64'(rom_addr), 64'h102);
    req_cs = 0;
    cyc(2);

    // Reset mid-fetch with rom_ok high
    req_cs = 3'b001; set_addr(0, 18'h55);
    rom_ok = 1; rom_data = 32'h1357_9BDF;
    cyc(3);
    check("rstf_pre_data", 64'(req_data), 64'h1357_9BDF);
    req_cs = 0; cyc(2);
    req_cs = 3'b001;
    cyc(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstf_cs", 64'(rom_cs), 0);
    check("rstf_gnt", 64'(req_gnt), 3);
    check("rstf_data", 64'(req_data), 0);
    #3 rst = 1'b0;
    req_cs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("rstf_no_ok", 64'(req_ok), 0);
    end
    rom_ok = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if ($urandom_range(7) == 0) req_cs[n] = ~req_cs[n];
        if ($urandom_range(15) == 0)
          set_addr(n, AW'({$urandom_range(3), 2'b00}));
      end
      rom_ok = ($urandom_range(9) < 7);
      rom_data = $urandom;
    end
    cyc(2);
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
